// File: rtl/misr_sig_if.sv
// Response/control bundle between the pattern-generator side and the MISR compactor.
// The master drives control and responses; the slave returns the handshake, signature and verdict.
interface misr_sig_if;
  logic       en;
  logic       start;
  logic [7:0] num_pat;
  logic [7:0] golden;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] sig;
  logic       busy;
  logic       done;
  logic       pass;

  modport master (
    output en, start, num_pat, golden, din, din_valid,
    input  din_ready, sig, busy, done, pass
  );

  modport slave (
    input  en, start, num_pat, golden, din, din_valid,
    output din_ready, sig, busy, done, pass
  );
endinterface

// File: rtl/misr_sig.sv
// 8-bit MISR response compactor (x^8+x^4+x^3+x^2+1) with a run counter and a registered golden compare.
// done/pass register on the edge that accepts the last response; din_ready is high only while running.
module misr_sig (
  input  logic        clk,
  input  logic        rst,
  misr_sig_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] sig_q, sig_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] npat_q, npat_d;
  logic       pass_q, pass_d;
  logic [7:0] misr_next;
  logic [7:0] cnt_inc;

  // Shift left, inject the response word, and fold bit 7 back into taps 0,2,3,4.
  assign misr_next = {sig_q[6:0], 1'b0} ^ bus.din ^ (sig_q[7] ? 8'h1D : 8'h00);
  assign cnt_inc   = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    npat_d  = npat_q;
    pass_d  = pass_q;
    if (bus.en) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            sig_d = 8'h00;
            cnt_d = 8'h00;
            if (bus.num_pat != 8'h00) begin
              npat_d  = bus.num_pat;
              pass_d  = 1'b0;
              state_d = ST_RUN;
            end else begin
              pass_d  = (bus.golden == 8'h00);
              state_d = ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (bus.din_valid) begin
            sig_d = misr_next;
            cnt_d = cnt_inc;
            // npat_q is never zero in RUN, so the counter stops before it could wrap.
            if (cnt_inc == npat_q) begin
              pass_d  = (misr_next == bus.golden);
              state_d = ST_DONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sig_q   <= 8'h00;
      cnt_q   <= 8'h00;
      npat_q  <= 8'h00;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      npat_q  <= npat_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.din_ready = (state_q == ST_RUN);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q & (state_q == ST_DONE);
  assign bus.sig       = sig_q;

endmodule
